// File: rtl/subblock_sched_pkg.sv
// rtl/subblock_sched_pkg.sv - shared types and defaults for the sub-block round-robin scheduler
package subblock_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int NUM_REQ_DEF    = 5;
    localparam int MAX_CYCLES_DEF = 200;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner select starting at ptr
module rr_pick #(
    parameter int NUM_REQ = 5,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx
);

    logic             found;
    logic [IDX_W:0]   pos;

    // Scan from ptr upward, folding back past NUM_REQ-1 without assuming a power of two.
    always_comb begin
        found      = 1'b0;
        winner_idx = '0;
        pos        = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(j);
            if (pos >= (IDX_W+1)'(NUM_REQ)) begin
                pos = pos - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && req[pos[IDX_W-1:0]]) begin
                found      = 1'b1;
                winner_idx = pos[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            winner[i] = found && (winner_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/subblock_rr_scheduler.sv
// rtl/subblock_rr_scheduler.sv - round-robin owner of one shared resource with done/watchdog release
module subblock_rr_scheduler
    import subblock_sched_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int MAX_CYCLES = MAX_CYCLES_DEF,
    parameter int CNT_W      = 8,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               res_start,
    input  logic               res_done,
    output logic               timeout_err,
    output logic [IDX_W-1:0]   err_idx
);

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               wd_hit;
    logic               release_now;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req),
        .ptr        (ptr),
        .winner     (pick_onehot),
        .winner_idx (pick_idx)
    );

    assign wd_hit      = (cnt == CNT_W'(MAX_CYCLES - 1));
    assign release_now = (state == BUSY) && (res_done || wd_hit);
    assign ptr_nxt     = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = START;
            START:   state_nxt = BUSY;
            BUSY:    if (res_done || wd_hit) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        res_start   = (state == START) && !rst;
        timeout_err = (state == BUSY) && wd_hit && !res_done && !rst;
        grant_valid = |grant;
    end

    // Grant is cleared on the edge leaving BUSY so RELEASE already shows it low.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant     <= '0;
            grant_idx <= '0;
            ptr       <= '0;
            cnt       <= '0;
            err_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant     <= pick_onehot;
                        grant_idx <= pick_idx;
                    end
                end
                START: cnt <= '0;
                BUSY: begin
                    if (release_now) begin
                        grant     <= '0;
                        grant_idx <= '0;
                        ptr       <= ptr_nxt;
                        if (!res_done) begin
                            err_idx <= grant_idx;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
